// File: rtl/stack_mem_responder.sv
// Memory-side stack responder: one request at a time, private word-addressed
// stack RAM, registered response behind a valid/ready handshake.
module stack_mem_responder #(
  parameter int unsigned             WIDTH     = 32,
  parameter int unsigned             DEPTH     = 64,
  parameter int unsigned             AW        = 6,
  parameter logic [WIDTH-1:0]        STACK_TOP = 32'd64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_is_ret,
  output logic [1:0]       resp_err,
  output logic [AW:0]      occupancy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [2:0]       OP_PUSH = 3'b001;
  localparam logic [2:0]       OP_POP  = 3'b010;
  localparam logic [2:0]       OP_CALL = 3'b011;
  localparam logic [2:0]       OP_RET  = 3'b100;
  localparam logic [WIDTH-1:0] BASE    = STACK_TOP - WIDTH'(DEPTH);
  localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             is_ret_q, is_ret_d;
  logic [1:0]       err_q, err_d;
  logic [AW:0]      occ_q, occ_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [WIDTH-1:0] offset;
  logic [AW-1:0]    idx;
  logic             in_range;
  logic             is_wr;
  logic             is_rd;

  // Offset from the stack base; a single unsigned compare covers both bounds
  // because anything below the base wraps to a large value.
  assign offset   = addr_q - BASE;
  assign idx      = offset[AW-1:0];
  assign in_range = (offset < WIDTH'(DEPTH));
  assign is_wr    = (op_q == OP_PUSH) || (op_q == OP_CALL);
  assign is_rd    = (op_q == OP_POP)  || (op_q == OP_RET);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    is_ret_d = is_ret_q;
    err_d    = err_q;
    occ_d    = occ_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        is_ret_d = (op_q == OP_RET);
        rdata_d  = '0;
        state_d  = RESP;
        if (!(is_wr || is_rd) || !in_range) begin
          err_d = 2'b11;
        end else if (is_wr && (occ_q == FULL)) begin
          err_d = 2'b01;
        end else if (is_rd && (occ_q == '0)) begin
          err_d = 2'b10;
        end else begin
          err_d = 2'b00;
          if (is_wr) begin
            mem_we = 1'b1;
            occ_d  = occ_q + 1'b1;
          end else begin
            rdata_d = mem[idx];
            occ_d   = occ_q - 1'b1;
          end
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      is_ret_q <= 1'b0;
      err_q    <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      is_ret_q <= is_ret_d;
      err_q    <= err_d;
      occ_q    <= occ_d;
    end
  end

  // Stack RAM is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_is_ret = is_ret_q;
  assign resp_err    = err_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_stack_mem_responder.sv
// Scoreboard bench for stack_mem_responder: directed requests push expected
// responses; a monitor pops and compares on each response handshake.
module tb_stack_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_is_ret;
  logic [1:0]  resp_err;
  logic [6:0]  occupancy;

  typedef struct {
    logic [31:0] rdata;
    logic        is_ret;
    logic [1:0]  err;
    logic [6:0]  occ;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  stack_mem_responder #(
    .WIDTH(32), .DEPTH(64), .AW(6), .STACK_TOP(32'd64)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_is_ret(resp_is_ret),
    .resp_err(resp_err), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted response against the scoreboard head.
  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_resp: got rdata %0h err %0d, none expected", resp_rdata, resp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_is_ret", 32'(resp_is_ret), 32'(e.is_ret));
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("occupancy", 32'(occupancy), 32'(e.occ));
      end
    end
  end

  // Drive one request; returns at the negedge just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic expect_resp, input logic [31:0] erd, input logic eret,
                       input logic [1:0] eerr, input logic [6:0] eocc);
    exp_t e;
    if (expect_resp) begin
      e.rdata = erd; e.is_ret = eret; e.err = eerr; e.occ = eocc;
      sb.push_back(e);
    end
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    // 1. asynchronous reset mid-cycle
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_is_ret", 32'(resp_is_ret), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 2. PUSH/POP round trip, with latency check on the PUSH
    issue(3'b001, 32'd63, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0, 2'b00, 7'd1);
    chk("lat_access_valid", 32'(resp_valid), 32'd0);
    chk("lat_access_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", 32'(resp_valid), 32'd1);
    wait_done();
    issue(3'b010, 32'd63, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 2'b00, 7'd0);
    wait_done();

    // 3. CALL/RET
    issue(3'b011, 32'd62, 32'h15, 1'b1, 32'd0, 1'b0, 2'b00, 7'd1);
    issue(3'b100, 32'd62, 32'd0, 1'b1, 32'h15, 1'b1, 2'b00, 7'd0);
    wait_done();

    // 4. underflow; RAM at 63 untouched, occupancy is independent of address
    issue(3'b010, 32'd63, 32'd0, 1'b1, 32'd0, 1'b0, 2'b10, 7'd0);
    issue(3'b100, 32'd62, 32'd0, 1'b1, 32'd0, 1'b1, 2'b10, 7'd0);
    issue(3'b001, 32'd10, 32'h1111, 1'b1, 32'd0, 1'b0, 2'b00, 7'd1);
    issue(3'b010, 32'd63, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 2'b00, 7'd0);
    wait_done();

    // 5. fill, overflow, range and opcode errors
    for (int i = 0; i < 64; i++)
      issue(3'b001, 32'(63 - i), 32'h1000 + 32'(i), 1'b1, 32'd0, 1'b0, 2'b00, 7'(i + 1));
    issue(3'b001, 32'd0, 32'hBAD, 1'b1, 32'd0, 1'b0, 2'b01, 7'd64);
    issue(3'b011, 32'd5, 32'hBAD, 1'b1, 32'd0, 1'b0, 2'b01, 7'd64);
    issue(3'b001, 32'd64, 32'hBAD, 1'b1, 32'd0, 1'b0, 2'b11, 7'd64);
    issue(3'b111, 32'd5, 32'hBAD, 1'b1, 32'd0, 1'b0, 2'b11, 7'd64);
    issue(3'b000, 32'd5, 32'hBAD, 1'b1, 32'd0, 1'b0, 2'b11, 7'd64);
    issue(3'b010, 32'd0, 32'd0, 1'b1, 32'h103F, 1'b0, 2'b00, 7'd63);
    issue(3'b100, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1'b1, 2'b11, 7'd63);
    issue(3'b010, 32'd32, 32'd0, 1'b1, 32'h101F, 1'b0, 2'b00, 7'd62);
    wait_done();

    // 6a. backpressure: response held, a new request ignored
    resp_ready = 1'b0;
    issue(3'b001, 32'd1, 32'h77, 1'b1, 32'd0, 1'b0, 2'b00, 7'd63);
    @(negedge clk);
    req_op = 3'b010; req_addr = 32'd1; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rdata", resp_rdata, 32'd0);
      chk("bp_err", 32'(resp_err), 32'd0);
      chk("bp_occ", 32'(occupancy), 32'd63);
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_done();
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("bp_ignored_occ", 32'(occupancy), 32'd63);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);

    // 6b. reset while a response is pending
    resp_ready = 1'b0;
    issue(3'b010, 32'd40, 32'd0, 1'b0, 32'd0, 1'b0, 2'b00, 7'd0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(resp_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    resp_ready = 1'b1;
    // occupancy restarted at 0; RAM written before reset is retained
    issue(3'b010, 32'd1, 32'd0, 1'b1, 32'd0, 1'b0, 2'b10, 7'd0);
    issue(3'b001, 32'd30, 32'h5, 1'b1, 32'd0, 1'b0, 2'b00, 7'd1);
    issue(3'b010, 32'd1, 32'd0, 1'b1, 32'h77, 1'b0, 2'b00, 7'd0);
    wait_done();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
